// File: rtl/fm_mod_if.sv
// FM modulator bus: audio sample input handshake and I/Q output handshake.
// The master drives audio samples and consumes I/Q pairs; the slave is fm_mod.
interface fm_mod_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] audio_din;
  logic                  audio_valid;
  logic                  audio_ready;
  logic [DATA_WIDTH-1:0] iq_i_dout;
  logic [DATA_WIDTH-1:0] iq_q_dout;
  logic                  iq_valid;
  logic                  iq_ready;

  modport master (
    output audio_din,
    output audio_valid,
    output iq_ready,
    input  audio_ready,
    input  iq_i_dout,
    input  iq_q_dout,
    input  iq_valid
  );

  modport slave (
    input  audio_din,
    input  audio_valid,
    input  iq_ready,
    output audio_ready,
    output iq_i_dout,
    output iq_q_dout,
    output iq_valid
  );
endinterface

// File: rtl/fm_mod.sv
// FM modulator: each accepted audio sample advances a continuous 32-bit phase
// accumulator AUDIO_DECIM times; each phase is turned into a quantized cos/sin
// pair by a 16-iteration rotation-mode CORDIC (one iteration per cycle).
// Optional feature macro: FM_MOD_INTERP_EN -- linear interpolation between the
// previous and current audio sample across the subsamples (default: hold).
module fm_mod #(
  parameter int     DATA_WIDTH  = 32,
  parameter int     BITS        = 10,
  parameter int     AUDIO_DECIM = 8,
  parameter longint FM_MOD_GAIN = 1048576
) (
  input  logic   clock,
  input  logic   reset,
  fm_mod_if.slave bus
);

  localparam int CW    = 24;             // CORDIC x/y datapath width
  localparam int FRAC  = 20;             // fractional bits of x/y
  localparam int SHIFT = FRAC - BITS;    // reduction to output scaling
  localparam int K_W   = (AUDIO_DECIM > 1) ? $clog2(AUDIO_DECIM) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(AUDIO_DECIM - 1);
`ifdef FM_MOD_INTERP_EN
  localparam int LOG2_DECIM = $clog2(AUDIO_DECIM);
`endif

  // 1/K pre-compensation seed so the CORDIC gain cancels out
  localparam logic signed [CW-1:0] X_INIT = 24'sd636751;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PHASE  = 2'd1;
  localparam logic [1:0] ST_ROTATE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  // atan(2^-i) expressed in phase units where 2^32 is one full turn
  function automatic logic [31:0] atan_lut(input logic [3:0] idx);
    logic [31:0] a;
    case (idx)
      4'd0:    a = 32'h2000_0000;
      4'd1:    a = 32'h12E4_051E;
      4'd2:    a = 32'h09FB_385B;
      4'd3:    a = 32'h0511_11D4;
      4'd4:    a = 32'h028B_0D43;
      4'd5:    a = 32'h0145_D7E1;
      4'd6:    a = 32'h00A2_F61E;
      4'd7:    a = 32'h0051_7C55;
      4'd8:    a = 32'h0028_BE53;
      4'd9:    a = 32'h0014_5F2F;
      4'd10:   a = 32'h000A_2F98;
      4'd11:   a = 32'h0005_17CC;
      4'd12:   a = 32'h0002_8BE6;
      4'd13:   a = 32'h0001_45F3;
      4'd14:   a = 32'h0000_A2FA;
      4'd15:   a = 32'h0000_517D;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

  // Arithmetic shift to BITS fractional bits, rounding toward zero, sign-extended
  function automatic logic [DATA_WIDTH-1:0] to_out_word(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] biased;
    logic signed [CW-1:0] shifted;
    if (v[CW-1] == 1'b1) begin
      biased = v + $signed(CW'((1 << SHIFT) - 1));
    end else begin
      biased = v;
    end
    shifted = biased >>> SHIFT;
    return DATA_WIDTH'(shifted);
  endfunction

  logic [1:0]            state_q, state_d;
  logic [31:0]           phase_q, phase_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
`ifdef FM_MOD_INTERP_EN
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic signed [63:0]    diff_s, ramp_s;
`endif
  logic signed [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [31:0]           z_q, z_d;
  logic [3:0]            it_q, it_d;
  logic [DATA_WIDTH-1:0] iq_i_q, iq_i_d, iq_q_q, iq_q_d;
  logic                  iq_valid_q, iq_valid_d;
  logic                  audio_ready_q, audio_ready_d;

  logic signed [63:0]    sub_s;
  logic [31:0]           inc_s;
  logic                  fold_s;
  logic signed [CW-1:0]  x_in_s, y_in_s, x_sh_s, y_sh_s, x_nx_s, y_nx_s;
  logic [31:0]           z_in_s, z_nx_s;

`ifdef FM_MOD_INTERP_EN
  // Subsample value interpolated from prev toward cur, then its phase increment
  always_comb begin
    diff_s = 64'($signed(cur_q)) - 64'($signed(prev_q));
    ramp_s = (diff_s * $signed(64'(k_q) + 64'd1)) >>> LOG2_DECIM;
    sub_s  = 64'($signed(prev_q)) + ramp_s;
    inc_s  = 32'(sub_s * FM_MOD_GAIN);
  end
`else
  // Subsample value held at the latched sample, then its phase increment
  always_comb begin
    sub_s = 64'($signed(cur_q));
    inc_s = 32'(sub_s * FM_MOD_GAIN);
  end
`endif

  // Phases in the left half-plane are rotated by -pi and the seed negated
  assign fold_s = phase_q[31] ^ phase_q[30];

  // One CORDIC micro-rotation; iteration 0 starts from the folded seed
  always_comb begin
    if (it_q == 4'd0) begin
      x_in_s = fold_s ? -X_INIT : X_INIT;
      y_in_s = {CW{1'b0}};
      z_in_s = fold_s ? (phase_q - 32'h8000_0000) : phase_q;
    end else begin
      x_in_s = x_q;
      y_in_s = y_q;
      z_in_s = z_q;
    end
    x_sh_s = x_in_s >>> it_q;
    y_sh_s = y_in_s >>> it_q;
    if (z_in_s[31] == 1'b0) begin
      x_nx_s = x_in_s - y_sh_s;
      y_nx_s = y_in_s + x_sh_s;
      z_nx_s = z_in_s - atan_lut(it_q);
    end else begin
      x_nx_s = x_in_s + y_sh_s;
      y_nx_s = y_in_s - x_sh_s;
      z_nx_s = z_in_s + atan_lut(it_q);
    end
  end

  // Sequencing: accept sample, accumulate phase, rotate, present I/Q pair
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    k_d        = k_q;
    cur_d      = cur_q;
`ifdef FM_MOD_INTERP_EN
    prev_d     = prev_q;
`endif
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    it_d       = it_q;
    iq_i_d     = iq_i_q;
    iq_q_d     = iq_q_q;
    iq_valid_d = iq_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.audio_valid && audio_ready_q) begin
          cur_d   = bus.audio_din;
          k_d     = {K_W{1'b0}};
          state_d = ST_PHASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PHASE: begin
        phase_d = phase_q + inc_s;
        it_d    = 4'd0;
        state_d = ST_ROTATE;
      end
      ST_ROTATE: begin
        x_d  = x_nx_s;
        y_d  = y_nx_s;
        z_d  = z_nx_s;
        it_d = it_q + 4'd1;
        if (it_q == 4'd15) begin
          iq_i_d     = to_out_word(x_nx_s);
          iq_q_d     = to_out_word(y_nx_s);
          iq_valid_d = 1'b1;
          state_d    = ST_OUTPUT;
        end else begin
          state_d = ST_ROTATE;
        end
      end
      ST_OUTPUT: begin
        if (iq_valid_q && bus.iq_ready) begin
          iq_valid_d = 1'b0;
          if (k_q == K_LAST) begin
`ifdef FM_MOD_INTERP_EN
            prev_d  = cur_q;
`endif
            state_d = ST_IDLE;
          end else begin
            k_d     = k_q + {{(K_W-1){1'b0}}, 1'b1};
            state_d = ST_PHASE;
          end
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    audio_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= 32'd0;
      k_q           <= {K_W{1'b0}};
      cur_q         <= {DATA_WIDTH{1'b0}};
`ifdef FM_MOD_INTERP_EN
      prev_q        <= {DATA_WIDTH{1'b0}};
`endif
      x_q           <= {CW{1'b0}};
      y_q           <= {CW{1'b0}};
      z_q           <= 32'd0;
      it_q          <= 4'd0;
      iq_i_q        <= {DATA_WIDTH{1'b0}};
      iq_q_q        <= {DATA_WIDTH{1'b0}};
      iq_valid_q    <= 1'b0;
      audio_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      k_q           <= k_d;
      cur_q         <= cur_d;
`ifdef FM_MOD_INTERP_EN
      prev_q        <= prev_d;
`endif
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      it_q          <= it_d;
      iq_i_q        <= iq_i_d;
      iq_q_q        <= iq_q_d;
      iq_valid_q    <= iq_valid_d;
      audio_ready_q <= audio_ready_d;
    end
  end

  assign bus.audio_ready = audio_ready_q;
  assign bus.iq_i_dout   = iq_i_q;
  assign bus.iq_q_dout   = iq_q_q;
  assign bus.iq_valid    = iq_valid_q;

endmodule

// File: tb/tb_fm_mod.sv
// Self-checking bench for fm_mod: a phase/trig model predicts every I/Q pair,
// plus directed latency, stall, reset and hand-computed output checks.
`timescale 1ns/1ps
module tb_fm_mod;
  localparam int     DW    = 32;
  localparam int     DECIM = 8;
  localparam longint GAIN  = 1048576;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fm_mod_if #(.DATA_WIDTH(DW)) bus ();

  fm_mod dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int unsigned mphase = 32'd0;
  longint      mprev  = 0;
  int          exp_i_q[$];
  int          exp_q_q[$];
  bit          stall_hold = 1'b0;
  longint      held_i, held_q;

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int ideal(input int unsigned ph, input bit want_sin);
    longint lp;
    real    ang;
    lp  = longint'(ph);
    ang = 6.283185307179586 * (real'(lp) / 4294967296.0);
    if (want_sin) return $rtoi(1024.0 * $sin(ang));
    else          return $rtoi(1024.0 * $cos(ang));
  endfunction

  // Expected I/Q for every subsample of one accepted audio sample
  task automatic model_burst(input longint s);
    for (int k = 0; k < DECIM; k++) begin
      longint sub;
`ifdef FM_MOD_INTERP_EN
      sub = mprev + (((s - mprev) * longint'(k + 1)) >>> $clog2(DECIM));
`else
      sub = s;
`endif
      mphase += 32'(sub * GAIN);
      exp_i_q.push_back(ideal(mphase, 1'b0));
      exp_q_q.push_back(ideal(mphase, 1'b1));
    end
    mprev = s;
  endtask

  task automatic model_clear();
    mphase = 32'd0;
    mprev  = 0;
    exp_i_q.delete();
    exp_q_q.delete();
  endtask

  // Compare process: every I/Q handshake against the model, holds while stalled
  always begin
    @(negedge clock);
    if (reset) begin
      stall_hold = 1'b0;
    end else if (bus.iq_valid) begin
      chk_range("audio_ready_during_iq", longint'(bus.audio_ready), 0, 0);
      if (stall_hold) begin
        chk_range("stall_hold_i", longint'($signed(bus.iq_i_dout)), held_i, held_i);
        chk_range("stall_hold_q", longint'($signed(bus.iq_q_dout)), held_q, held_q);
      end
      if (bus.iq_ready) begin
        stall_hold = 1'b0;
        total++;
        if (exp_i_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_iq: got 1 pair want 0 pending");
        end else begin
          int ei, eq;
          ei = exp_i_q.pop_front();
          eq = exp_q_q.pop_front();
          chk_range("model_i", longint'($signed(bus.iq_i_dout)), ei - 2, ei + 2);
          chk_range("model_q", longint'($signed(bus.iq_q_dout)), eq - 2, eq + 2);
        end
      end else begin
        stall_hold = 1'b1;
        held_i     = longint'($signed(bus.iq_i_dout));
        held_q     = longint'($signed(bus.iq_q_dout));
      end
    end
  end

  // Waits for audio_ready, performs one audio handshake, feeds the model
  task automatic send_audio(input longint s);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (bus.audio_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_range("audio_ready_timeout", longint'(ok), 1, 1);
    if (ok) begin
      bus.audio_din   = 32'(s);
      bus.audio_valid = 1'b1;
      @(posedge clock);
      model_burst(s);
      #1;
      bus.audio_valid = 1'b0;
      bus.audio_din   = 32'd0;
    end
  endtask

  // Counts negedges after the current point until iq_valid (0 on timeout)
  task automatic wait_iq(output int n);
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.iq_valid) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int     n;
    int     zero_valid;
    longint cap_i, cap_q;

    bus.audio_din   = 32'd0;
    bus.audio_valid = 1'b0;
    bus.iq_ready    = 1'b1;
    reset           = 1'b1;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk_range("reset_audio_ready", longint'(bus.audio_ready), 0, 0);
    chk_range("reset_iq_valid", longint'(bus.iq_valid), 0, 0);
    chk_range("reset_i", longint'($signed(bus.iq_i_dout)), 0, 0);
    chk_range("reset_q", longint'($signed(bus.iq_q_dout)), 0, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_range("ready_after_reset", longint'(bus.audio_ready), 1, 1);

`ifdef FM_MOD_INTERP_EN
    // Ramp from 0 to 1024: total phase 4.5 turns-of-2^30 -> 2^29
    send_audio(0);
    send_audio(1024);
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (exp_i_q.size() == 0 && bus.audio_ready) break;
    end
    chk_range("interp_model_phase", longint'(mphase), 536870912, 536870912);
    reset = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
`endif

    // Zero audio: phase stays 0, I near 1024, Q near 0
    send_audio(0);
    wait_iq(n);
    chk_range("latency_zero", n, 18, 18);
    chk_range("zero_i", longint'($signed(bus.iq_i_dout)), 1022, 1026);
    chk_range("zero_q", longint'($signed(bus.iq_q_dout)), -2, 2);

    // +1024: quarter turn per subsample
    send_audio(1024);
    wait_iq(n);
    chk_range("latency_pos", n, 18, 18);
`ifndef FM_MOD_INTERP_EN
    chk_range("pos_first_i", longint'($signed(bus.iq_i_dout)), -2, 2);
    chk_range("pos_first_q", longint'($signed(bus.iq_q_dout)), 1022, 1026);
`endif

    // -1024: negative increment, wraps below zero
    send_audio(-1024);
    wait_iq(n);
    chk_range("latency_neg", n, 18, 18);
`ifndef FM_MOD_INTERP_EN
    chk_range("neg_first_i", longint'($signed(bus.iq_i_dout)), -2, 2);
    chk_range("neg_first_q", longint'($signed(bus.iq_q_dout)), -1026, -1022);
`endif

    // Downstream stall: pair held, audio not accepted, next pair 18 after release
    send_audio(1024);
    bus.iq_ready = 1'b0;
    wait_iq(n);
    chk_range("latency_stall_first", n, 18, 18);
    cap_i = longint'($signed(bus.iq_i_dout));
    cap_q = longint'($signed(bus.iq_q_dout));
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      chk_range("stall_valid", longint'(bus.iq_valid), 1, 1);
      chk_range("stall_audio_ready", longint'(bus.audio_ready), 0, 0);
      chk_range("stall_i", longint'($signed(bus.iq_i_dout)), cap_i, cap_i);
      chk_range("stall_q", longint'($signed(bus.iq_q_dout)), cap_q, cap_q);
    end
    bus.iq_ready = 1'b1;
    @(posedge clock);
    wait_iq(n);
    chk_range("latency_after_stall", n, 18, 18);

    // Reset during rotation aborts the pair and clears the phase
    send_audio(1024);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_range("abort_iq_valid", longint'(bus.iq_valid), 0, 0);
    chk_range("abort_i", longint'($signed(bus.iq_i_dout)), 0, 0);
    chk_range("abort_q", longint'($signed(bus.iq_q_dout)), 0, 0);
    chk_range("abort_ready_in_reset", longint'(bus.audio_ready), 0, 0);
    @(posedge clock);
    #1;
    chk_range("abort_ready_after", longint'(bus.audio_ready), 1, 1);
    zero_valid = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.iq_valid) zero_valid++;
    end
    chk_range("abort_no_iq", zero_valid, 0, 0);
    send_audio(0);
    wait_iq(n);
    chk_range("latency_after_abort", n, 18, 18);
    chk_range("after_abort_i", longint'($signed(bus.iq_i_dout)), 1022, 1026);
    chk_range("after_abort_q", longint'($signed(bus.iq_q_dout)), -2, 2);

    // Drain: every predicted pair must have been delivered
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (exp_i_q.size() == 0 && bus.audio_ready) break;
    end
    chk_range("drain_pending", longint'(exp_i_q.size()), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
